// File: rtl/over_index_gen.sv
// Game-over banner index generator: slide-in animation, hit test, ROM pipeline.
// Define OVER_BLINK_EN to blink the banner while it holds in place.
module over_index_gen #(
  parameter int SPRITE_W     = 256,
  parameter int SPRITE_H     = 64,
  parameter int X0           = 192,
  parameter int Y_TARGET     = 208,
  parameter int SLIDE_STEP   = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int ROM_AW       = 14
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              game_over,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        over_index,
  output logic              over_active
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = ROM_AW - CW;

  localparam logic signed [10:0] Y_START = 11'(-SPRITE_H);
  localparam logic signed [10:0] Y_TGT   = 11'(Y_TARGET);
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + SPRITE_W);
  localparam logic [11:0] H12  = 12'(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE,
    SLIDE,
    HOLD
  } state_t;

  state_t state, state_nx;
  logic signed [10:0] y_pos, y_nx, y_step;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      y_pos <= Y_START;
    end else begin
      state <= state_nx;
      y_pos <= y_nx;
    end
  end

  assign y_step = y_pos + 11'(SLIDE_STEP);

  always_comb begin
    state_nx = state;
    y_nx     = y_pos;
    if (!game_over) begin
      state_nx = IDLE;
      y_nx     = Y_START;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = SLIDE;
          y_nx     = Y_START;
        end
        SLIDE: begin
          if (frame_start) begin
            y_nx = (y_step >= Y_TGT) ? Y_TGT : y_step;
            if (y_nx == Y_TGT)
              state_nx = HOLD;
          end
        end
        HOLD: y_nx = Y_TGT;
        default: begin
          state_nx = IDLE;
          y_nx     = Y_START;
        end
      endcase
    end
  end

  // Row offset is computed one bit wider so tall DrawY never wraps negative.
  logic [10:0]   x11;
  logic [11:0]   dy;
  logic [CW-1:0] dx;
  logic          in_x, in_y, hit;
  logic [ROM_AW-1:0] addr;

  assign x11  = {1'b0, DrawX};
  assign dy   = {2'b00, DrawY} - {y_pos[10], y_pos};
  assign dx   = CW'(x11 - X_LO);
  assign in_x = (x11 >= X_LO) && (x11 < X_HI);
  assign in_y = !dy[11] && (dy < H12);
  assign hit  = in_x && in_y && (state != IDLE) && game_over;
  assign addr = hit ? {dy[RW-1:0], dx} : '0;

  logic vis;

`ifdef OVER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (state != HOLD || state_nx != HOLD) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        vis       <= ~vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign vis = 1'b1;
`endif

  logic hit_d1, hit_d2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr    <= '0;
      hit_d1      <= 1'b0;
      hit_d2      <= 1'b0;
      over_index  <= '0;
      over_active <= 1'b0;
    end else if (!game_over) begin
      rom_addr    <= '0;
      hit_d1      <= 1'b0;
      hit_d2      <= 1'b0;
      over_index  <= '0;
      over_active <= 1'b0;
    end else begin
      rom_addr    <= addr;
      hit_d1      <= hit;
      hit_d2      <= hit_d1;
      over_index  <= (hit_d2 && vis) ? rom_q : 4'h0;
      over_active <= hit_d2 && vis;
    end
  end

endmodule
